// File: rtl/result_reader_if.sv
// rtl/result_reader_if.sv - control, RAM read port and result stream bundle for result_reader.
// RESULT_CHECKSUM_EN adds the checksum signal.
interface result_reader_if;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  ram_raddr;
  logic [31:0] ram_out;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [7:0]  count;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0] checksum;

  modport slave (
    input  start, len, ram_out, out_ready,
    output ram_raddr, out_data, out_valid, busy, done, count, checksum
  );
  modport master (
    output start, len, ram_out, out_ready,
    input  ram_raddr, out_data, out_valid, busy, done, count, checksum
  );
`else
  modport slave (
    input  start, len, ram_out, out_ready,
    output ram_raddr, out_data, out_valid, busy, done, count
  );
  modport master (
    output start, len, ram_out, out_ready,
    input  ram_raddr, out_data, out_valid, busy, done, count
  );
`endif
endinterface

// File: rtl/result_reader.sv
// rtl/result_reader.sv - reads len consecutive results from RAM and streams them out.
// RESULT_CHECKSUM_EN adds a running 32-bit sum of transferred beats.
module result_reader #(
  parameter logic [7:0] BASE_ADDR = 8'd200,
  parameter int         READ_LAT  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  result_reader_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_FIN} state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_raddr;
  logic [7:0]  r_len;
  logic [7:0]  r_count;
  logic [31:0] r_data;
  logic [1:0]  r_lat_cnt;
  logic        w_xfer;
  logic        w_last;
  logic        w_out_valid;
  logic        w_busy;
  logic        w_done;

  assign w_xfer = (r_state == S_HOLD) && bus.out_ready;
  assign w_last = (r_count + 8'd1) == r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = (bus.len == 8'd0) ? S_FIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == 2'd0) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_xfer) begin
          w_next = w_last ? S_FIN : S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers; RAM data is captured only on the last WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr   <= 8'd0;
      r_len     <= 8'd0;
      r_count   <= 8'd0;
      r_data    <= 32'd0;
      r_lat_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_count <= 8'd0;
            if (bus.len != 8'd0) begin
              r_raddr   <= BASE_ADDR;
              r_len     <= bus.len;
              r_lat_cnt <= LAT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_lat_cnt != 2'd0) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
          end else begin
            r_data <= bus.ram_out;
          end
        end
        S_HOLD: begin
          if (w_xfer) begin
            r_count <= r_count + 8'd1;
            if (!w_last) begin
              r_raddr   <= r_raddr + 8'd1;
              r_lat_cnt <= LAT_INIT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= 32'd0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_checksum <= 32'd0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + r_data;
    end
  end

  assign bus.checksum = r_checksum;
`endif

  // Flags decode straight from the registered state, so reset clears them at once.
  always_comb begin
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  w_busy      = 1'b0;
      S_HOLD:  w_out_valid = 1'b1;
      S_FIN:   w_done      = 1'b1;
      default: begin
      end
    endcase
  end

  assign bus.ram_raddr = r_raddr;
  assign bus.out_data  = r_data;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - self-checking bench for result_reader against a RAM-array reference model.
module tb_result_reader;
  localparam logic [7:0] BASE = 8'd200;
  localparam int         RL   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  string cur_tag;

  result_reader_if bus ();

  result_reader #(.BASE_ADDR(BASE), .READ_LAT(RL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One registered RAM stage: address registered at edge 0 gives data sampled at edge 2.
  logic [31:0] mem [256];
  logic [31:0] ram_q;
  always @(posedge clk) ram_q <= mem[bus.ram_raddr];
  assign bus.ram_out = ram_q;

  typedef struct {
    logic [7:0] len;
    int         rdy_pct;
    int         stall_beat;
    int         stall_n;
    logic [7:0] exp_count;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%h expected=%h", cur_tag, nm, act, exp);
    end
  endtask

  task automatic do_run(input string tag, input logic [7:0] n, input int rdy_pct,
                        input int stall_beat, input int stall_n, input logic [7:0] exp_count);
    int          beat;
    int          k;
    int          stall_left;
    int          issue_k;
    logic        pv;
    logic        pstall;
    logic [31:0] pdata;
    logic [7:0]  paddr;
    logic [7:0]  addr0;
    logic [7:0]  exp_addr;
    logic [31:0] exp_sum;
    cur_tag = tag;
    beat = 0; k = 0; stall_left = stall_n; issue_k = 0;
    pv = 1'b0; pstall = 1'b0; pdata = 32'd0; paddr = 8'd0; exp_sum = 32'd0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    addr0 = bus.ram_raddr;
    bus.start = 1'b1;
    bus.len   = n;
    @(negedge clk);
    bus.start = 1'b0;
    if (n != 8'd0) chk("addr_first", 32'(bus.ram_raddr), 32'(BASE));
    while (beat < int'(n) && k < 4000) begin
      if (pstall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", bus.out_data, pdata);
        chk("hold_addr", 32'(bus.ram_raddr), 32'(paddr));
      end
      if (bus.out_valid && !pv) chk("latency", 32'(k), 32'(issue_k + RL));
      chk("done_low", 32'(bus.done), 32'd0);
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      if (beat == stall_beat && bus.out_valid && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end
      bus.start = ($urandom_range(7) == 0);
      bus.len   = 8'($urandom);
      if (bus.out_valid && bus.out_ready) begin
        exp_addr = 8'(int'(BASE) + beat);
        chk("beat_data", bus.out_data, mem[exp_addr]);
        chk("beat_addr", 32'(bus.ram_raddr), 32'(exp_addr));
        chk("beat_count", 32'(bus.count), 32'(beat));
        exp_sum += mem[exp_addr];
        beat++;
        issue_k = k + 1;
      end
      pstall = bus.out_valid && !bus.out_ready;
      pdata  = bus.out_data;
      paddr  = bus.ram_raddr;
      pv     = bus.out_valid;
      @(negedge clk);
      k++;
    end
    if (beat < int'(n)) chk("timeout_beats", 32'(beat), 32'(n));
    exp_addr = (n == 8'd0) ? addr0 : 8'(int'(BASE) + int'(n) - 1);
    chk("fin_done", 32'(bus.done), 32'd1);
    chk("fin_busy", 32'(bus.busy), 32'd1);
    chk("fin_valid", 32'(bus.out_valid), 32'd0);
    chk("fin_count", 32'(bus.count), 32'(exp_count));
    chk("fin_addr", 32'(bus.ram_raddr), 32'(exp_addr));
`ifdef RESULT_CHECKSUM_EN
    chk("fin_csum", bus.checksum, exp_sum);
`endif
    // start coincident with done must be ignored
    bus.start = 1'b1;
    bus.len   = 8'd7;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_count", 32'(bus.count), 32'(exp_count));
    chk("post_addr", 32'(bus.ram_raddr), 32'(exp_addr));
  endtask

  vec_t vecs [6];

  initial begin
    checks = 0;
    errors = 0;
    cur_tag = "reset";
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[200] = 32'd5;
    mem[201] = 32'd7;
    mem[202] = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.len = 8'd0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_addr", 32'(bus.ram_raddr), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{len: 8'd3,  rdy_pct: 100, stall_beat: -1, stall_n: 0, exp_count: 8'd3};
    vecs[1] = '{len: 8'd3,  rdy_pct: 100, stall_beat: 1,  stall_n: 4, exp_count: 8'd3};
    vecs[2] = '{len: 8'd0,  rdy_pct: 100, stall_beat: -1, stall_n: 0, exp_count: 8'd0};
    vecs[3] = '{len: 8'd60, rdy_pct: 100, stall_beat: -1, stall_n: 0, exp_count: 8'd60};
    vecs[4] = '{len: 8'd1,  rdy_pct: 100, stall_beat: -1, stall_n: 0, exp_count: 8'd1};
    vecs[5] = '{len: 8'd10, rdy_pct: 50,  stall_beat: -1, stall_n: 0, exp_count: 8'd10};
    for (int v = 0; v < 6; v++) begin
      do_run($sformatf("vec%0d", v), vecs[v].len, vecs[v].rdy_pct,
             vecs[v].stall_beat, vecs[v].stall_n, vecs[v].exp_count);
    end

    for (int r = 0; r < 8; r++) begin
      logic [7:0] rn;
      rn = 8'($urandom_range(0, 40));
      do_run($sformatf("rand%0d", r), rn, int'($urandom_range(30, 100)), -1, 0, rn);
    end

    // Asynchronous reset while holding beat 2 of 5
    cur_tag = "midrst";
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && bus.count != 8'd1; i++) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    chk("pre_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_count", 32'(bus.count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_addr", 32'(bus.ram_raddr), 32'd0);
    chk("async_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run("after_rst", 8'd1, 100, -1, 0, 8'd1);

`ifdef RESULT_CHECKSUM_EN
    mem[200] = 32'd1;
    mem[201] = 32'd2;
    mem[202] = 32'd3;
    do_run("csum123", 8'd3, 100, -1, 0, 8'd3);
    chk("csum_6", bus.checksum, 32'd6);
    mem[200] = 32'hFFFF_FFFF;
    mem[201] = 32'd2;
    do_run("csum_wrap", 8'd2, 70, -1, 0, 8'd2);
    chk("csum_1", bus.checksum, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
